// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with single-cycle ops plus an iterative
// multiply/divide unit holding results in HI/LO.
// Ports:
//   clk, rstn         clock (rising edge), asynchronous active-low reset
//   A, B, ALUOp       operands and operation code
//   start             launch a mul/div op (honoured only when idle)
//   C, Zero           combinational result and (C == 0)
//   busy, done        registered handshake: busy while iterating, done pulse
//   hi, lo            result registers (product high/low, remainder/quotient)
module alu_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned HALF = WIDTH / 2;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_NOR  = 5'd9;
  localparam logic [4:0] OP_LUI  = 5'd10;
  localparam logic [4:0] OP_SRA  = 5'd11;
  localparam logic [4:0] OP_XOR  = 5'd12;
  localparam logic [4:0] OP_MFHI = 5'd20;
  localparam logic [4:0] OP_MFLO = 5'd21;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sa_q, sa_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d;

  logic [SHW-1:0]   shamt;
  assign shamt = A[SHW-1:0];

  // Single-cycle result mux; mul/div launch codes and unknown codes pass A
  always_comb begin
    C = A;
    case (ALUOp)
      OP_ADD:  C = A + B;
      OP_SUB:  C = A - B;
      OP_AND:  C = A & B;
      OP_OR:   C = A | B;
      OP_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  C = B << shamt;
      OP_SRL:  C = B >> shamt;
      OP_NOR:  C = ~(A | B);
      OP_LUI:  C = B << HALF;
      OP_SRA:  C = WIDTH'($signed(B) >>> shamt);
      OP_XOR:  C = A ^ B;
      OP_MFHI: C = hi;
      OP_MFLO: C = lo;
      default: C = A;
    endcase
  end

  assign Zero = (C == {WIDTH{1'b0}});

  // Launch decode: 16..19 are MULT/MULTU/DIV/DIVU; bit0 set means unsigned
  logic             is_md, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign is_md = (ALUOp[4:2] == 3'b100);
  assign sgn   = ~ALUOp[0];
  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  // MIN maps onto itself, which read unsigned is exactly its magnitude
  assign mag_a = a_neg ? -A : A;
  assign mag_b = b_neg ? -B : B;

  // One iteration: shift-add multiply on {acc,q}, or restoring divide step
  logic [WIDTH:0]   mul_sum, div_part;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub, acc_step, q_step;
  logic [W2-1:0]    prod, prod_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, (q_q[0] ? mb_q : {WIDTH{1'b0}})};
    div_part = {acc_q, q_q[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, mb_q});
    div_sub  = div_part[WIDTH-1:0] - mb_q;
    if (is_div_q) begin
      acc_step = div_ge ? div_sub : div_part[WIDTH-1:0];
      q_step   = {q_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      q_step   = {mul_sum[0], q_q[WIDTH-1:1]};
    end
    prod     = {acc_step, q_step};
    prod_fix = neg_q ? -prod : prod;
  end

  // Next-state and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    q_d      = q_q;
    hi_d     = hi;
    lo_d     = lo;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_md) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = ALUOp[1];
          sa_d     = a_neg;
          // Divide by zero keeps the raw all-ones quotient unsigned
          neg_d    = (a_neg ^ b_neg) & ~(ALUOp[1] && (B == {WIDTH{1'b0}}));
          mb_d     = mag_b;
          acc_d    = '0;
          q_d      = mag_a;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        q_d   = q_step;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = sa_q ? -acc_step : acc_step;
            lo_d = neg_q ? -q_step : q_step;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      mb_q     <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      neg_q    <= neg_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      hi       <= hi_d;
      lo       <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH = 32) against an arithmetic reference model.
module tb_alu_md;
  localparam int W = 32;
  localparam logic [4:0] ADD = 5'd1, SUB = 5'd2, SLT = 5'd5, SLTU = 5'd6, SLL = 5'd7;
  localparam logic [4:0] SRL = 5'd8, NOR = 5'd9, LUI = 5'd10, SRA = 5'd11, XOR = 5'd12;
  localparam logic [4:0] MULT = 5'd16, MULTU = 5'd17, DIV = 5'd18, DIVU = 5'd19;
  localparam logic [4:0] MFHI = 5'd20, MFLO = 5'd21;

  logic clk = 1'b0, rstn;
  logic [W-1:0] A, B, C, hi, lo;
  logic [4:0] ALUOp;
  logic start, Zero, busy, done;

  int n_vec = 0, n_err = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .A(A), .B(B), .ALUOp(ALUOp), .start(start),
    .C(C), .Zero(Zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference single-cycle result
  function automatic logic [W-1:0] alu_ref(input logic [4:0] op, input logic [W-1:0] a, b, h, l);
    int unsigned sh;
    logic [W-1:0] fill;
    sh = a % 32;
    fill = b[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      5'd0:  return a;
      5'd1:  return a + b;
      5'd2:  return a - b;
      5'd3:  return a & b;
      5'd4:  return a | b;
      5'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd6:  return (a < b) ? 32'd1 : 32'd0;
      5'd7:  return b << sh;
      5'd8:  return b >> sh;
      5'd9:  return ~(a | b);
      5'd10: return b * 32'd65536;
      5'd11: return (b >> sh) | fill;
      5'd12: return a ^ b;
      5'd20: return h;
      5'd21: return l;
      default: return a;
    endcase
  endfunction

  // Reference mul/div result using 64-bit arithmetic
  task automatic md_ref(input logic [4:0] op, input logic [W-1:0] a, b, output logic [W-1:0] h, l);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'h0, a}; ub = {32'h0, b};
    p = '0;
    case (op)
      MULT:  p = 64'(sa * sb);
      MULTU: p = 64'(ua * ub);
      DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    {h, l} = p;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; A = '0; B = '0; ALUOp = MFHI;
    #3;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got %h exp 0", hi); end
    n_vec++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got %h exp 0", lo); end
    n_vec++; if (C !== '0) begin n_err++; $display("FAIL reset_mfhi got %h exp 0", C); end
    @(negedge clk); rstn = 1'b1;
  endtask

  logic [4:0]   d_op[12] = '{ADD, SUB, SLT, SLTU, SRA, SLL, LUI, NOR, XOR, SRL, SRA, 5'd13};
  logic [W-1:0] d_a[12]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'h24,
                             32'h0, 32'h0, 32'hF0F0, 32'h21, 32'h1F, 32'hABC};
  logic [W-1:0] d_b[12]  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h8000_0000, 32'd1,
                             32'h1234, 32'h0, 32'hFF00, 32'h8000_0000, 32'h8000_0000, 32'h5};
  logic [W-1:0] d_c[12]  = '{32'h8000_0000, 32'h0, 32'd1, 32'd0, 32'hF800_0000, 32'h10,
                             32'h1234_0000, 32'hFFFF_FFFF, 32'h0FF0, 32'h4000_0000, 32'hFFFF_FFFF, 32'hABC};

  task automatic test_alu_directed();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); ALUOp = d_op[i]; A = d_a[i]; B = d_b[i]; #1;
      n_vec++;
      if (C !== d_c[i]) begin n_err++; $display("FAIL alu_dir[%0d] op=%0d got %h exp %h", i, d_op[i], C, d_c[i]); end
      n_vec++;
      if (Zero !== (d_c[i] == 0)) begin n_err++; $display("FAIL zero_dir[%0d] got %b exp %b", i, Zero, d_c[i] == 0); end
    end
  endtask

  task automatic test_alu_random();
    logic [W-1:0] e;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      ALUOp = 5'($urandom_range(0, 31));
      A = $urandom; B = $urandom;
      if (i % 8 == 0) B = A;
      #1;
      e = alu_ref(ALUOp, A, B, m_hi, m_lo);
      n_vec++;
      if (C !== e || Zero !== (e == 0)) begin
        n_err++; $display("FAIL alu_rand op=%0d a=%h b=%h got %h/%b exp %h/%b", ALUOp, A, B, C, Zero, e, e == 0);
      end
    end
  endtask

  // Launch one mul/div op and check the full busy/done window; poke re-asserts start
  task automatic run_md(input logic [4:0] op, input logic [W-1:0] a, b, input bit poke);
    logic [W-1:0] eh, el;
    bit busy_ok, done_ok;
    md_ref(op, a, b, eh, el);
    @(negedge clk); A = a; B = b; ALUOp = op; start = 1'b1;
    @(posedge clk);
    busy_ok = 1; done_ok = 1;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      start = poke && (k == 5 || k == W || k == W + 1);
      A = $urandom; B = $urandom; ALUOp = start ? DIVU : 5'd0;
      #1;
      if (busy !== (k <= W)) busy_ok = 0;
      if (done !== (k == W + 1)) done_ok = 0;
      if (k == W + 1) begin
        n_vec++; if (hi !== eh) begin n_err++; $display("FAIL md_hi op=%0d a=%h b=%h got %h exp %h", op, a, b, hi, eh); end
        n_vec++; if (lo !== el) begin n_err++; $display("FAIL md_lo op=%0d a=%h b=%h got %h exp %h", op, a, b, lo, el); end
        ALUOp = MFHI; #1;
        n_vec++; if (C !== eh) begin n_err++; $display("FAIL mfhi got %h exp %h", C, eh); end
        ALUOp = MFLO; #1;
        n_vec++; if (C !== el) begin n_err++; $display("FAIL mflo got %h exp %h", C, el); end
        if (start) ALUOp = MULT;
      end
    end
    start = 1'b0;
    n_vec++; if (!busy_ok) begin n_err++; $display("FAIL busy_window op=%0d got bad exp cycles 1..%0d", op, W); end
    n_vec++; if (!done_ok) begin n_err++; $display("FAIL done_window op=%0d got bad exp single pulse at %0d", op, W + 1); end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_md_directed();
    run_md(MULT, 32'hFFFF_FFFD, 32'd7, 0);
    n_vec++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin n_err++; $display("FAIL mult_plan got %h_%h", hi, lo); end
    run_md(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    n_vec++; if ({hi, lo} !== {32'hFFFF_FFFE, 32'h1}) begin n_err++; $display("FAIL multu_plan got %h_%h", hi, lo); end
    run_md(DIV, 32'hFFFF_FFF9, 32'd2, 0);
    n_vec++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL div_plan got %h_%h", hi, lo); end
    run_md(DIVU, 32'd100, 32'd7, 0);
    n_vec++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_plan got %h_%h", hi, lo); end
    run_md(DIVU, 32'd5, 32'd0, 0);
    n_vec++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL divu_zero got %h_%h", hi, lo); end
    run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    n_vec++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin n_err++; $display("FAIL div_ovf got %h_%h", hi, lo); end
    run_md(DIV, 32'hFFFF_FFF9, 32'd0, 0);
    run_md(DIV, 32'h8000_0000, 32'd3, 0);
  endtask

  task automatic test_md_random();
    logic [4:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 5'(16 + $urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i % 5 == 0) b = -b;
      run_md(op, a, b, 0);
    end
  endtask

  task automatic test_back_to_back();
    run_md(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    run_md(DIV, 32'hDEAD_BEEF, 32'h0000_1234, 1);
  endtask

  task automatic test_start_ignored();
    bit ok;
    @(negedge clk); ALUOp = ADD; A = 32'd9; B = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1; if (busy !== 1'b0 || done !== 1'b0) ok = 0;
      @(negedge clk);
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL start_add got busy/done activity exp none"); end
    n_vec++; if ({hi, lo} !== {m_hi, m_lo}) begin n_err++; $display("FAIL start_add_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); A = 32'd1000; B = 32'd7; ALUOp = DIV; start = 1'b1;
    @(negedge clk); start = 1'b0; ALUOp = 5'd0;
    repeat (9) @(negedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midop_busy got %b exp 1", busy); end
    n_vec++; if ({hi, lo} === 64'h0) begin n_err++; $display("FAIL midop_hilo got 0 exp nonzero prior result"); end
    rstn = 1'b0; #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctl got %b%b exp 00", busy, done); end
    n_vec++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL rst_mid_hilo got %h_%h exp 0", hi, lo); end
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy got %b exp 0", busy); end
    run_md(MULT, 32'd2, 32'd3, 0);
    n_vec++; if ({hi, lo} !== {32'd0, 32'd6}) begin n_err++; $display("FAIL post_rst_mult got %h_%h exp 0_6", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_md_directed();
    test_md_random();
    test_back_to_back();
    test_start_ignored();
    test_alu_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
